ifu_prefetch: RTL and testbench

Instruction-fetch unit that sits directly upstream of the `if_id` register and the decoder. It generates the fetch PC and issues in-order requests on a req/gnt/rvalid instruction bus. A static backward-taken/forward-not-taken predictor redirects the PC; `prdt_taken_o` carries that decision downstream so `ex` can correct a wrong guess. Fetched words are held in a 2-entry prefetch buffer, so bus latency and pipeline holds are decoupled.

---
 rtl/ifu_prefetch_pkg.sv | 21 ++
 rtl/ifu_fifo.sv | 57 +++++
 rtl/ifu_prefetch.sv | 163 ++++++++++++++++
 tb/tb_ifu_prefetch.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_prefetch_pkg.sv
// ifu_prefetch_pkg
// Shared constants and types for the instruction-fetch prefetch unit:
// opcode values used by the predecoder, the NOP presented when the buffer
// is empty, the default reset PC and the layout of one prefetch-buffer entry.
package ifu_prefetch_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0001;
    localparam logic [6:0]  INST_JAL         = 7'b110_1111;
    localparam logic [6:0]  INST_TYPE_B      = 7'b110_0011;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Prefetch buffer depth; also bounds the number of outstanding requests.
    localparam int unsigned BUF_DEPTH = 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        prdt;
    } buf_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo
// Two-entry synchronous FIFO with simultaneous push/pop at any occupancy.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             drop all entries (synchronous)
//   push, push_data write side; a push while full is accepted only with a pop
//   pop, pop_data   read side; pop_data is the head, valid when !empty
//   full, empty     occupancy flags
//   count           number of stored entries (0..2)
module ifu_fifo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt != 2'd0);
    // When full, the slot being written is the one being read out this cycle.
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (cnt == 2'd2);
    assign empty    = (cnt == 2'd0);
    assign count    = cnt;

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch
// Instruction-fetch unit: generates the fetch PC, issues in-order requests on
// a req/gnt/rvalid bus, predecodes returned words with a static
// backward-taken / forward-not-taken predictor and holds fetched words in a
// two-entry prefetch buffer feeding the decode stage.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   jump_flag_i, jump_addr_i      redirect from execute (highest priority)
//   hold_i                        downstream stall, head is not consumed
//   ibus_req_o, ibus_addr_o       fetch request and word address
//   ibus_gnt_i                    request accepted this cycle
//   ibus_rvalid_i, ibus_rdata_i   in-order read response
//   inst_valid_o                  buffer head valid
//   inst_o, inst_addr_o           head instruction (NOP when empty) and PC
//   prdt_taken_o                  head was predicted taken
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    // Only a depth of 2 is supported by the buffer and tag queue.
    parameter int unsigned DEPTH    = BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        prdt_taken_o
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [1:0]  outstanding;
    logic [1:0]  outstanding_next;
    logic [1:0]  discard;
    logic [1:0]  discard_next;
    logic [2:0]  in_use;

    logic        issue;
    logic        resp;
    logic        keep;
    logic        taken;
    logic [6:0]  opcode;
    logic        is_jal;
    logic        is_bwd_b;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic [31:0] target;

    logic [31:0] tag_addr;
    logic        tag_full;
    logic        tag_empty;
    logic [1:0]  tag_count;

    buf_entry_t  wr_entry;
    buf_entry_t  head;
    logic        buf_pop;
    logic        buf_full;
    logic        buf_empty;
    logic [1:0]  buf_count;

    // Occupancy is implied by the outstanding counter; flags kept for debug.
    logic        unused_flags;
    assign unused_flags = ^{tag_full, tag_empty, tag_count, buf_full};

    // Issue: requests stop once buffered plus in-flight words fill the buffer,
    // so every response always has a free slot to land in.
    always_comb begin
        in_use     = {1'b0, outstanding} + {1'b0, buf_count};
        ibus_req_o = !rst && !jump_flag_i && (in_use < 3'(DEPTH));
    end

    assign ibus_addr_o = pc;
    assign issue       = ibus_req_o && ibus_gnt_i;
    assign resp        = ibus_rvalid_i;

    // Predecode of the returning word, tagged with its fetch address.
    assign opcode   = ibus_rdata_i[6:0];
    assign is_jal   = (opcode == INST_JAL);
    assign is_bwd_b = (opcode == INST_TYPE_B) && ibus_rdata_i[31];
    assign imm_j    = {{12{ibus_rdata_i[31]}}, ibus_rdata_i[19:12], ibus_rdata_i[20],
                       ibus_rdata_i[30:21], 1'b0};
    assign imm_b    = {{20{ibus_rdata_i[31]}}, ibus_rdata_i[7], ibus_rdata_i[30:25],
                       ibus_rdata_i[11:8], 1'b0};
    assign target   = tag_addr + (is_jal ? imm_j : imm_b);

    assign keep  = resp && (discard == 2'd0) && !jump_flag_i;
    assign taken = keep && (is_jal || is_bwd_b);

    always_comb begin
        outstanding_next = outstanding + {1'b0, issue} - {1'b0, resp};
        pc_next          = pc;
        discard_next     = discard;
        if (jump_flag_i) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_next      = jump_addr_i;
            discard_next = outstanding - {1'b0, resp};
        end else if (taken) begin
            // Squash fetches younger than the taken word, including one
            // granted in this same cycle.
            pc_next      = target;
            discard_next = outstanding - 2'd1 + {1'b0, issue};
        end else begin
            if (issue) pc_next = pc + 32'd4;
            if (resp && (discard != 2'd0)) discard_next = discard - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= 2'd0;
            discard     <= 2'd0;
        end else begin
            pc          <= pc_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
        end
    end

    ifu_fifo #(.WIDTH(32)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .push      (issue),
        .push_data (pc),
        .pop       (resp),
        .pop_data  (tag_addr),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    assign wr_entry = '{inst: ibus_rdata_i, addr: tag_addr, prdt: taken};
    assign buf_pop  = !buf_empty && !hold_i;

    ifu_fifo #(.WIDTH($bits(buf_entry_t))) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (jump_flag_i),
        .push      (keep),
        .push_data (wr_entry),
        .pop       (buf_pop),
        .pop_data  (head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign inst_valid_o = !buf_empty;
    assign inst_o       = buf_empty ? INST_NOP : head.inst;
    assign inst_addr_o  = buf_empty ? 32'd0    : head.addr;
    assign prdt_taken_o = !buf_empty && head.prdt;

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch
// Self-checking bench for ifu_prefetch: a cycle table for reset and linear
// fetch, then directed sequences driven through a small in-order bus model
// (branches, flush, hold) and a randomized-latency run checked against a
// program-order reference of the test program.
module tb_ifu_prefetch;

    localparam logic [31:0] NOP_EMPTY = 32'h0000_0001;
    localparam logic [31:0] MEM_NOP   = 32'h0000_0013;
    localparam logic [31:0] BEQ_M8    = 32'hFE00_0CE3;  // beq x0,x0,-8
    localparam logic [31:0] BNE_P16   = 32'h0000_1863;  // bne x0,x0,+16
    localparam logic [31:0] JAL_P100  = 32'h1000_006F;  // jal x0,+0x100
    localparam logic [31:0] JALR_X1   = 32'h0000_8067;  // jalr x0,0(x1)

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        hold;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        prdt;

    always #5 clk = ~clk;

    ifu_prefetch #(.RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag),
        .jump_addr_i   (jump_addr),
        .hold_i        (hold),
        .ibus_req_o    (req),
        .ibus_addr_o   (addr),
        .ibus_gnt_i    (gnt),
        .ibus_rvalid_i (rvalid),
        .ibus_rdata_i  (rdata),
        .inst_valid_o  (inst_valid),
        .inst_o        (inst),
        .inst_addr_o   (inst_addr),
        .prdt_taken_o  (prdt)
    );

    int errors = 0;
    int checks = 0;
    int prog;
    int cyc;
    int last_ready;
    int lat_min;
    int lat_max;
    int gnt_pct;

    typedef struct {
        logic [31:0] a;
        int          ready;
    } pend_t;

    typedef struct {
        logic        rvalid;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] iaddr;
        logic [31:0] inst;
    } vec_t;

    pend_t       pend[$];
    logic [31:0] issued[$];
    logic [31:0] cons_a[$];
    logic        cons_p[$];
    logic [31:0] exp_q[$];
    vec_t        tv[8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = MEM_NOP;
        case (prog)
            1: if (a == 32'h10) w = BEQ_M8;
            2: begin
                if (a == 32'h08) w = BNE_P16;
                else if (a == 32'h20) w = JAL_P100;
            end
            3: begin
                case (a)
                    32'h08:  w = BNE_P16;
                    32'h0C:  w = JALR_X1;
                    32'h10:  w = JAL_P100;
                    32'h114: w = BEQ_M8;
                    default: w = MEM_NOP;
                endcase
            end
            default: w = MEM_NOP;
        endcase
        return w;
    endfunction

    // Program-order successor of each address in program 3.
    function automatic logic [31:0] ref_next(input logic [31:0] a);
        if (a == 32'h10)  return 32'h110;
        if (a == 32'h114) return 32'h10C;
        return a + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; jump_flag = 1'b0; jump_addr = 32'h0; hold = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        pend.delete(); issued.delete(); cons_a.delete(); cons_p.delete();
        last_ready = -1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset req", req, 0);
        chk("reset valid", inst_valid, 0);
        chk("reset inst", inst, NOP_EMPTY);
        chk("reset inst_addr", inst_addr, 0);
        chk("reset prdt", prdt, 0);
        cyc = -1;
    endtask

    // One bus cycle: apply inputs at the falling edge, let the bus model
    // answer, then log grants and consumed instructions.
    task automatic tick(input logic j, input logic [31:0] ja, input logic h);
        int r;
        @(negedge clk);
        rst = 1'b0; jump_flag = j; jump_addr = ja; hold = h;
        cyc++;
        if (pend.size() > 0 && pend[0].ready <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_word(pend[0].a);
            pend.delete(0);
        end else begin
            rvalid = 1'b0;
            rdata  = 32'hDEAD_BEEF;
        end
        gnt = ($urandom_range(99) < gnt_pct);
        #1;
        if (req && gnt) begin
            r = cyc + 1 + int'($urandom_range(lat_max, lat_min));
            if (r <= last_ready) r = last_ready + 1;
            last_ready = r;
            pend.push_back('{addr, r});
            issued.push_back(addr);
        end
        if (inst_valid && !hold && !jump_flag) begin
            cons_a.push_back(inst_addr);
            cons_p.push_back(prdt);
        end
    endtask

    task automatic check_seq(input string name);
        chk({name, " count"}, 32'(cons_a.size() >= exp_q.size()), 1);
        for (int i = 0; i < exp_q.size() && i < cons_a.size(); i++)
            chk($sformatf("%s[%0d]", name, i), cons_a[i], exp_q[i]);
    endtask

    initial begin
        int          k;
        int          n;
        int          mark;
        logic [31:0] a;

        gnt_pct = 100; lat_min = 0; lat_max = 0; prog = 0;

        // Reset and linear fetch, zero-wait bus, cycle 0 = first cycle out of reset.
        tv[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0, NOP_EMPTY};
        tv[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0, NOP_EMPTY};
        tv[2] = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h0, MEM_NOP};
        tv[3] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h4, MEM_NOP};
        tv[4] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h0, NOP_EMPTY};
        tv[5] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h8, MEM_NOP};
        tv[6] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'hC, MEM_NOP};
        tv[7] = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h0, NOP_EMPTY};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst = 1'b0; jump_flag = 1'b0; hold = 1'b0; gnt = 1'b1;
            rvalid = tv[i].rvalid; rdata = MEM_NOP;
            #1;
            chk($sformatf("lin c%0d req", i), req, tv[i].req);
            chk($sformatf("lin c%0d addr", i), addr, tv[i].addr);
            chk($sformatf("lin c%0d valid", i), inst_valid, tv[i].valid);
            chk($sformatf("lin c%0d inst_addr", i), inst_addr, tv[i].iaddr);
            chk($sformatf("lin c%0d inst", i), inst, tv[i].inst);
            chk($sformatf("lin c%0d prdt", i), prdt, 0);
        end

        // Backward branch at 0x10 loops to 0x08; in-flight 0x14 is squashed.
        prog = 1;
        do_reset();
        repeat (40) tick(1'b0, 32'h0, 1'b0);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h8, 32'hC, 32'h10};
        check_seq("bwd");
        chk("bwd prdt 0x0C", cons_p[3], 0);
        chk("bwd prdt 0x10", cons_p[4], 1);
        chk("bwd prdt 0x10 again", cons_p[7], 1);
        n = 0;
        foreach (cons_a[i]) if (cons_a[i] == 32'h14) n++;
        chk("bwd 0x14 never valid", n, 0);
        k = -1;
        for (int i = 0; i < issued.size(); i++)
            if (k < 0 && issued[i] == 32'h14) k = i;
        chk("bwd 0x14 issued", 32'(k >= 0), 1);
        if (k >= 0 && k + 1 < issued.size()) chk("bwd issue after 0x14", issued[k+1], 32'h8);

        // Forward BNE not taken, JAL taken to 0x120.
        prog = 2;
        do_reset();
        repeat (40) tick(1'b0, 32'h0, 1'b0);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
                  32'h20, 32'h120, 32'h124, 32'h128};
        check_seq("fwd");
        chk("fwd bne prdt", cons_p[2], 0);
        chk("fwd jal prdt", cons_p[8], 1);
        chk("fwd target prdt", cons_p[9], 0);
        n = 0;
        foreach (cons_a[i]) if (cons_a[i] == 32'h24) n++;
        chk("fwd 0x24 never valid", n, 0);

        // Flush with two outstanding while a response arrives.
        prog = 0; lat_min = 1; lat_max = 1;
        do_reset();
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'h200, 1'b0);
        chk("flush req low", req, 0);
        tick(1'b0, 32'h0, 1'b0);
        chk("flush buf empty", inst_valid, 0);
        chk("flush req J+1", req, 1);
        chk("flush addr J+1", addr, 32'h200);
        repeat (12) tick(1'b0, 32'h0, 1'b0);
        exp_q = '{32'h200, 32'h204, 32'h208};
        check_seq("flush");
        // Flush while the buffer holds words.
        mark = cons_a.size();
        repeat (5) tick(1'b0, 32'h0, 1'b1);
        tick(1'b1, 32'h300, 1'b1);
        chk("flush2 head before", inst_valid, 1);
        tick(1'b0, 32'h0, 1'b0);
        chk("flush2 cleared", inst_valid, 0);
        repeat (15) tick(1'b0, 32'h0, 1'b0);
        chk("flush2 count", 32'(cons_a.size() >= mark + 2), 1);
        chk("flush2 first", cons_a[mark], 32'h300);
        chk("flush2 second", cons_a[mark+1], 32'h304);

        // Hold for 5 cycles: head frozen, requests stop, no loss on release.
        lat_min = 0; lat_max = 0;
        do_reset();
        repeat (6) tick(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 32'h0, 1'b1);
            chk($sformatf("hold%0d valid", i), inst_valid, 1);
            chk($sformatf("hold%0d head", i), inst_addr, 32'hC);
            if (i >= 2) chk($sformatf("hold%0d req", i), req, 0);
        end
        repeat (30) tick(1'b0, 32'h0, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 15; i++) exp_q.push_back(32'(i * 4));
        check_seq("hold");

        // Random grant, latency 0..3 and hold against program-order reference.
        prog = 3; gnt_pct = 60; lat_min = 0; lat_max = 3;
        do_reset();
        for (int i = 0; i < 400; i++) tick(1'b0, 32'h0, $urandom_range(4) == 0);
        chk("rand progress", 32'(cons_a.size() >= 40), 1);
        a = 32'h0;
        for (int i = 0; i < cons_a.size(); i++) begin
            chk($sformatf("rand addr[%0d]", i), cons_a[i], a);
            chk($sformatf("rand prdt[%0d]", i), cons_p[i], 32'(a == 32'h10 || a == 32'h114));
            a = ref_next(a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
